// File: rtl/uart_receiver_if.sv
// uart_receiver_if: received-byte handshake and status pulses between the UART receiver and its consumer
interface uart_receiver_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;
  modport master(output data_out, data_out_valid, framing_error, overrun, input data_out_ready);
  modport slave(input data_out, data_out_valid, framing_error, overrun, output data_out_ready);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first UART receiver with mid-bit sampling, glitch rejection, framing and overrun flags
module uart_receiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            serial_in,
  uart_receiver_if.master rx_if
);
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = SYMBOL_EDGE_TIME > 1 ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [CW-1:0] SYM_LAST = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] SMP_LAST = CW'(SAMPLE_TIME - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            rx;
  logic            free;
  assign rx     = sync_q[1];
  assign sync_d = {sync_q[0], serial_in};
  // the output register can take a new byte if empty or being drained this cycle
  assign free   = ~valid_q | rx_if.data_out_ready;
  assign rx_if.data_out       = data_q;
  assign rx_if.data_out_valid = valid_q;
  assign rx_if.framing_error  = ferr_q;
  assign rx_if.overrun        = ovr_q;
  // frame sequencing, bit sampling and output-register handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx_if.data_out_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = rx ? IDLE : START;
      end
      START: if (cnt_q == SMP_LAST) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx ? IDLE : DATA;
      end
      DATA: if (cnt_q == SYM_LAST) begin
        cnt_d   = '0;
        shift_d = {rx, shift_q[7:1]};
        idx_d   = idx_q + 1'b1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (cnt_q == SYM_LAST) begin
        cnt_d   = '0;
        state_d = rx ? IDLE : WAIT_IDLE;
        ferr_d  = ~rx;
        ovr_d   = rx & ~free;
        data_d  = rx && free ? shift_q : data_q;
        valid_d = rx && free ? 1'b1 : valid_d;
      end
      WAIT_IDLE: state_d = rx ? IDLE : WAIT_IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous reset; synchronizer resets to the idle line level
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives serial frames and checks received bytes and status pulses against a frame-level model
module tb_uart_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int valid_cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rx_n = 0;
  logic [7:0] rx_log [0:255];
  uart_receiver_if bus();
  uart_receiver #(.CLOCK_FREQ(2_500), .BAUD_RATE(250)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .rx_if(bus.master)
  );
  always #5 clk = ~clk;
  // observe handshake transfers and status pulses midway between rising edges
  always @(negedge clk) begin
    if (!rst) begin
      valid_cyc <= valid_cyc + int'(bus.data_out_valid);
      fe_cnt    <= fe_cnt + int'(bus.framing_error);
      ov_cnt    <= ov_cnt + int'(bus.overrun);
      if (bus.data_out_valid && bus.data_out_ready) begin
        rx_log[rx_n[7:0]] <= bus.data_out;
        rx_n <= rx_n + 1;
      end
    end
  end
  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic send(input logic [7:0] b, input logic stop = 1'b1);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2 serial_in = f[i];
      repeat (9) @(posedge clk);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.data_out_ready = 1'b0;
    step(3);
    n_vec++; if (bus.data_out !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h exp 00", bus.data_out); end
    n_vec++; if (bus.data_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", bus.data_out_valid); end
    n_vec++; if (bus.framing_error !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b exp 0", bus.framing_error); end
    n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b exp 0", bus.overrun); end
    rst = 1'b0;
    step(5);
  endtask
  task automatic test_single();
    int v0, f0, o0, r0;
    v0 = valid_cyc; f0 = fe_cnt; o0 = ov_cnt; r0 = rx_n;
    bus.data_out_ready = 1'b1;
    send(8'hA5);
    step(10);
    n_vec++; if (rx_n - r0 !== 1) begin n_err++; $display("FAIL single_count: got %0d exp 1", rx_n - r0); end
    n_vec++; if (rx_log[r0[7:0]] !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h exp a5", rx_log[r0[7:0]]); end
    n_vec++; if (valid_cyc - v0 !== 1) begin n_err++; $display("FAIL single_valid_cycles: got %0d exp 1", valid_cyc - v0); end
    n_vec++; if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin n_err++; $display("FAIL single_pulses: got fe %0d ov %0d exp 0 0", fe_cnt - f0, ov_cnt - o0); end
  endtask
  task automatic test_overrun();
    int f0, o0, r0;
    f0 = fe_cnt; o0 = ov_cnt; r0 = rx_n;
    bus.data_out_ready = 1'b0;
    send(8'h3C);
    send(8'h81);
    step(20);
    n_vec++; if (bus.data_out !== 8'h3C) begin n_err++; $display("FAIL overrun_data: got %h exp 3c", bus.data_out); end
    n_vec++; if (bus.data_out_valid !== 1'b1) begin n_err++; $display("FAIL overrun_valid: got %b exp 1", bus.data_out_valid); end
    n_vec++; if (ov_cnt - o0 !== 1) begin n_err++; $display("FAIL overrun_pulses: got %0d exp 1", ov_cnt - o0); end
    n_vec++; if (fe_cnt - f0 !== 0 || rx_n - r0 !== 0) begin n_err++; $display("FAIL overrun_side: got fe %0d xfers %0d exp 0 0", fe_cnt - f0, rx_n - r0); end
  endtask
  task automatic test_ready_at_load();
    int o0, r0;
    o0 = ov_cnt; r0 = rx_n;
    fork
      send(8'h81);
      begin
        repeat (98) @(posedge clk);
        #2 bus.data_out_ready = 1'b1;
        @(posedge clk);
        #2 bus.data_out_ready = 1'b0;
      end
    join
    step(5);
    n_vec++; if (bus.data_out !== 8'h81) begin n_err++; $display("FAIL load_data: got %h exp 81", bus.data_out); end
    n_vec++; if (bus.data_out_valid !== 1'b1) begin n_err++; $display("FAIL load_valid: got %b exp 1", bus.data_out_valid); end
    n_vec++; if (ov_cnt - o0 !== 0) begin n_err++; $display("FAIL load_overrun: got %0d exp 0", ov_cnt - o0); end
    n_vec++; if (rx_n - r0 !== 1 || rx_log[r0[7:0]] !== 8'h3C) begin n_err++; $display("FAIL load_xfer: got %0d/%h exp 1/3c", rx_n - r0, rx_log[r0[7:0]]); end
    bus.data_out_ready = 1'b1;
    step(3);
    n_vec++; if (rx_log[(r0 + 1) & 255] !== 8'h81) begin n_err++; $display("FAIL drain_data: got %h exp 81", rx_log[(r0 + 1) & 255]); end
    n_vec++; if (bus.data_out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b exp 0", bus.data_out_valid); end
  endtask
  task automatic test_glitch();
    int v0, f0, o0;
    v0 = valid_cyc; f0 = fe_cnt; o0 = ov_cnt;
    serial_in = 1'b0;
    step(3);
    serial_in = 1'b1;
    step(120);
    n_vec++; if (valid_cyc - v0 !== 0) begin n_err++; $display("FAIL glitch_valid: got %0d exp 0", valid_cyc - v0); end
    n_vec++; if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin n_err++; $display("FAIL glitch_pulses: got fe %0d ov %0d exp 0 0", fe_cnt - f0, ov_cnt - o0); end
  endtask
  task automatic test_framing();
    int v0, f0, r0;
    v0 = valid_cyc; f0 = fe_cnt; r0 = rx_n;
    bus.data_out_ready = 1'b1;
    send(8'h55, 1'b0);
    step(30);
    serial_in = 1'b1;
    step(20);
    n_vec++; if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL framing_pulses: got %0d exp 1", fe_cnt - f0); end
    n_vec++; if (valid_cyc - v0 !== 0) begin n_err++; $display("FAIL framing_valid: got %0d exp 0", valid_cyc - v0); end
    send(8'h0F);
    step(10);
    n_vec++; if (rx_n - r0 !== 1 || rx_log[r0[7:0]] !== 8'h0F) begin n_err++; $display("FAIL framing_next: got %0d/%h exp 1/0f", rx_n - r0, rx_log[r0[7:0]]); end
    n_vec++; if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL framing_after: got %0d exp 1", fe_cnt - f0); end
  endtask
  task automatic test_reset_mid();
    logic [7:0] b;
    int f0, o0, r0;
    b = 8'($urandom);
    bus.data_out_ready = 1'b0;
    send(b);
    step(10);
    n_vec++; if (bus.data_out !== b || bus.data_out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_held: got %h/%b exp %h/1", bus.data_out, bus.data_out_valid, b); end
    fork
      send(8'($urandom) | 8'hF0);
      begin
        repeat (58) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        n_vec++; if (bus.data_out !== 8'h00 || bus.data_out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out: got %h/%b exp 00/0", bus.data_out, bus.data_out_valid); end
        n_vec++; if (bus.framing_error !== 1'b0 || bus.overrun !== 1'b0) begin n_err++; $display("FAIL rmid_pulses: got %b/%b exp 0/0", bus.framing_error, bus.overrun); end
      end
    join
    step(20);
    f0 = fe_cnt; o0 = ov_cnt; r0 = rx_n;
    n_vec++; if (bus.data_out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_tail: got %b exp 0", bus.data_out_valid); end
    bus.data_out_ready = 1'b1;
    send(8'h7E);
    step(10);
    n_vec++; if (rx_n - r0 !== 1 || rx_log[r0[7:0]] !== 8'h7E) begin n_err++; $display("FAIL rmid_next: got %0d/%h exp 1/7e", rx_n - r0, rx_log[r0[7:0]]); end
    n_vec++; if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin n_err++; $display("FAIL rmid_next_pulses: got fe %0d ov %0d exp 0 0", fe_cnt - f0, ov_cnt - o0); end
  endtask
  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int exp_fe, f0, o0, r0;
    exp_fe = 0; f0 = fe_cnt; o0 = ov_cnt; r0 = rx_n;
    bus.data_out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        send(b);
        exp_q.push_back(b);
        step($urandom_range(0, 6));
      end else begin
        send(b, 1'b0);
        exp_fe++;
        #2 serial_in = 1'b1;
        step(10 + $urandom_range(0, 6));
      end
    end
    step(20);
    n_vec++; if (rx_n - r0 !== exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d exp %0d", rx_n - r0, exp_q.size()); end
    foreach (exp_q[i]) begin
      n_vec++; if (rx_log[(r0 + i) & 255] !== exp_q[i]) begin n_err++; $display("FAIL rand_byte%0d: got %h exp %h", i, rx_log[(r0 + i) & 255], exp_q[i]); end
    end
    n_vec++; if (fe_cnt - f0 !== exp_fe) begin n_err++; $display("FAIL rand_ferr: got %0d exp %0d", fe_cnt - f0, exp_fe); end
    n_vec++; if (ov_cnt - o0 !== 0) begin n_err++; $display("FAIL rand_ovr: got %0d exp 0", ov_cnt - o0); end
  endtask
  initial begin
    bus.data_out_ready = 1'b0;
    test_reset();
    test_single();
    test_overrun();
    test_ready_at_load();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
